// File: rtl/cd_multi_divider.sv
// cd_multi_divider: N-channel programmable clock divider with a shared config port.
// Each channel divides clk by 2*(limit+1). A new limit is staged in a shadow register
// and applied only at a falling boundary of clk_out, so no output pulse is ever cut short
// by a limit change. An enable-mask register gates each channel.
// Optional feature macro: CDM_TICK_EN adds the tick output (one pulse per rising clk_out).
module cd_multi_divider #(
   parameter int                NUM_CH            = 4,
   parameter int                WIDTH_LIMIT       = 24,
   parameter int                WIDTH_CONFIG_ADDR = 4,
   parameter int                WIDTH_CONFIG_DATA = 24,
   parameter int                RST_LIMIT         = 1,
   parameter logic [NUM_CH-1:0] RST_EN            = '1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
   input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
   input  logic                         c_valid,
   output logic                         c_ready,
   output logic                         c_err,
`ifdef CDM_TICK_EN
   output logic [NUM_CH-1:0]            clk_out,
   output logic [NUM_CH-1:0]            tick
`else
   output logic [NUM_CH-1:0]            clk_out
`endif
);

   // Address of the enable-mask register; channel limits occupy 0..NUM_CH-1.
   localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_EN  = WIDTH_CONFIG_ADDR'(NUM_CH);
   localparam logic [WIDTH_LIMIT-1:0]       LIMIT_RV = WIDTH_LIMIT'(RST_LIMIT);

   logic [NUM_CH-1:0]      en;
   logic [NUM_CH-1:0]      pending;
   logic [WIDTH_LIMIT-1:0] cnt    [NUM_CH];
   logic [WIDTH_LIMIT-1:0] limit  [NUM_CH];
   logic [WIDTH_LIMIT-1:0] shadow [NUM_CH];
   logic                   busy;
   logic                   accept;

   // Back-pressure a limit write while that channel still has an unapplied shadow.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      busy = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pending[i] && (c_addr == WIDTH_CONFIG_ADDR'(i))) busy = 1'b1;
      end
      c_ready = ~rst & ~busy;
   end

   assign accept = c_valid & c_ready;

   // Enable mask register and out-of-range error pulse.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         en    <= RST_EN;
         c_err <= 1'b0;
      end else begin
         c_err <= accept && (c_addr > ADDR_EN);
         if (accept && (c_addr == ADDR_EN)) en <= c_data[NUM_CH-1:0];
      end
   end

   // Per-channel counter, output toggle, shadow staging and glitch-free limit apply.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: these arrays are control state with defined reset values, so they are reset
         // explicitly; they are small register files, not RAM.
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            limit[i]  <= LIMIT_RV;
            shadow[i] <= LIMIT_RV;
         end
         pending <= '0;
         clk_out <= '0;
`ifdef CDM_TICK_EN
         tick    <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
`ifdef CDM_TICK_EN
            tick[i] <= en[i] && (cnt[i] == limit[i]) && !clk_out[i];
`endif
            if (en[i]) begin
               if (cnt[i] == limit[i]) begin
                  cnt[i]     <= '0;
                  clk_out[i] <= ~clk_out[i];
                  // Falling boundary: the old period is complete, safe to switch limits.
                  if (clk_out[i] && pending[i]) begin
                     limit[i]   <= shadow[i];
                     pending[i] <= 1'b0;
                  end
               end else begin
                  cnt[i] <= cnt[i] + WIDTH_LIMIT'(1);
               end
            end else begin
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               if (pending[i]) begin
                  limit[i]   <= shadow[i];
                  pending[i] <= 1'b0;
               end
            end
            // A write is never accepted while pending is set, so it cannot collide with an apply.
            if (accept && (c_addr == WIDTH_CONFIG_ADDR'(i))) begin
               shadow[i]  <= c_data[WIDTH_LIMIT-1:0];
               pending[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cd_multi_divider.sv
// Testbench for cd_multi_divider: directed scenarios followed by random config traffic,
// all compared cycle by cycle against a phase-countdown reference model.
module tb_cd_multi_divider;

   localparam int NUM_CH    = 4;
   localparam int WL        = 24;
   localparam int WA        = 4;
   localparam int WD        = 24;
   localparam int RST_LIMIT = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [WA-1:0] c_addr = '0;
   logic [WD-1:0] c_data = '0;
   logic          c_valid = 1'b0;
   logic          c_ready;
   logic          c_err;
   logic [NUM_CH-1:0] clk_out;
`ifdef CDM_TICK_EN
   logic [NUM_CH-1:0] tick;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   cd_multi_divider #(
      .NUM_CH(NUM_CH), .WIDTH_LIMIT(WL), .WIDTH_CONFIG_ADDR(WA),
      .WIDTH_CONFIG_DATA(WD), .RST_LIMIT(RST_LIMIT), .RST_EN('1)
   ) dut (
      .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
      .c_ready(c_ready), .c_err(c_err),
`ifdef CDM_TICK_EN
      .clk_out(clk_out), .tick(tick)
`else
      .clk_out(clk_out)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: each channel counts down the cycles left in its current half-period.
   int  m_lim    [NUM_CH];
   int  m_shadow [NUM_CH];
   int  m_left   [NUM_CH];
   bit  m_pend   [NUM_CH];
   bit  m_lvl    [NUM_CH];
   bit  m_en     [NUM_CH];
   bit  m_err;
   logic [NUM_CH-1:0] m_tick;

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_lim[i] = RST_LIMIT; m_shadow[i] = RST_LIMIT; m_left[i] = RST_LIMIT + 1;
         m_pend[i] = 0; m_lvl[i] = 0; m_en[i] = 1;
      end
      m_err = 0; m_tick = '0;
   endfunction

   function automatic bit model_ready(bit r, int a);
      if (r) return 0;
      if (a < NUM_CH) return !m_pend[a];
      return 1;
   endfunction

   // Advances the model by one clock edge; returns whether the write was accepted.
   function automatic bit model_step(bit r, bit v, int a, int d);
      bit acc;
      acc = v && model_ready(r, a);
      m_err = 0; m_tick = '0;
      if (r) begin
         model_reset();
         return 0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (m_en[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
               if (m_lvl[i] && m_pend[i]) begin
                  m_lim[i] = m_shadow[i]; m_pend[i] = 0;
               end
               m_lvl[i]  = !m_lvl[i];
               m_tick[i] = m_lvl[i];
               m_left[i] = m_lim[i] + 1;
            end
         end else begin
            if (m_pend[i]) begin
               m_lim[i] = m_shadow[i]; m_pend[i] = 0;
            end
            m_lvl[i]  = 0;
            m_left[i] = m_lim[i] + 1;
         end
      end
      if (acc) begin
         if (a < NUM_CH) begin
            m_shadow[a] = d & ((1 << WL) - 1); m_pend[a] = 1;
         end else if (a == NUM_CH) begin
            for (int i = 0; i < NUM_CH; i++) m_en[i] = d[i];
         end else begin
            m_err = 1;
         end
      end
      return acc;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, check c_ready, then outputs after posedge.
   task automatic step(input bit r, input bit v, input int a, input int d, output bit acc);
      logic [NUM_CH-1:0] exp_out;
      @(negedge clk);
      rst = r; c_valid = v; c_addr = WA'(a); c_data = WD'(d);
      #1;
      check("c_ready", 32'(c_ready), 32'(model_ready(r, a)));
      acc = model_step(r, v, a, d);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_CH; i++) exp_out[i] = m_lvl[i];
      check("clk_out", 32'(clk_out), 32'(exp_out));
      check("c_err", 32'(c_err), 32'(m_err));
`ifdef CDM_TICK_EN
      check("tick", 32'(tick), 32'(m_tick));
`endif
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, acc);
   endtask

   // Holds c_valid until the write is accepted, within a bounded number of cycles.
   task automatic cfg_write(input int a, input int d);
      bit acc;
      bit done;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         step(0, 1, a, d, acc);
         done = acc;
      end
      check("write_accepted", 32'(done), 32'd1);
   endtask

   // Idles until channel ch reaches the requested level, within a bounded number of cycles.
   task automatic wait_level(input int ch, input bit lvl);
      bit acc;
      bit done;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         if (m_lvl[ch] == lvl) done = 1;
         else step(0, 0, 0, 0, acc);
      end
      check("wait_level", 32'(done), 32'd1);
   endtask

   initial begin
      bit acc;
      int a;
      int d;
      model_reset();

      // Reset, then free-run at RST_LIMIT: period 4, first rise two cycles after release.
      step(1, 0, 0, 0, acc);
      step(1, 0, 0, 0, acc);
      check("reset_clk_out", 32'(clk_out), 32'd0);
      check("reset_c_err", 32'(c_err), 32'd0);
      idle(16);

      // Limit change on ch0 during its low phase; a second write is back-pressured.
      wait_level(0, 0);
      cfg_write(0, 3);
      cfg_write(0, 3);
      idle(30);

      // Enable mask: disable ch1/ch3, then re-enable all.
      cfg_write(NUM_CH, 4'b0101);
      idle(6);
      cfg_write(NUM_CH, 4'b1111);
      idle(10);

      // Out-of-range write: ready, single c_err pulse, no state change.
      cfg_write(NUM_CH + 2, 5);
      idle(8);

      // ch2 limit 0, then reset during its high phase.
      cfg_write(2, 0);
      idle(4);
      wait_level(2, 1);
      step(1, 0, 0, 0, acc);
      check("midrst_clk_out", 32'(clk_out), 32'd0);
      idle(12);

      // ch0 limit 2: period 6 (tick every 6 cycles when enabled).
      cfg_write(0, 2);
      idle(30);

      // Random traffic: limit writes, mask writes, bad addresses, occasional reset.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 99) < 2) begin
            step(1, 0, 0, 0, acc);
         end else if ($urandom_range(0, 99) < 20) begin
            a = $urandom_range(0, NUM_CH + 3);
            d = (a == NUM_CH) ? int'($urandom_range(0, 15)) | 1 : int'($urandom_range(0, 5));
            step(0, 1, a, d, acc);
         end else begin
            step(0, 0, 0, 0, acc);
         end
      end
      idle(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
